rr_lsb_arbiter: RTL and testbench

- Parametrised round-robin arbiter built on lowest-set-bit isolation; grant is one-hot, registered and fair across NUM_REQ requesters.
- Search starts at a rotating priority pointer and wraps through index 0.
- Sits in front of shared resources (bus ports, memory banks) in the datapath.
- LOCK mode holds a grant until the grantee acknowledges, for multi-beat transfers.

---
 rtl/arb_pkg.sv | 16 +
 rtl/lsb_isolate_vec.sv | 11 +
 rtl/rr_lsb_arbiter.sv | 52 +++++
 tb/tb_rr_lsb_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and bit helpers for the round-robin arbiter
package arb_pkg;
  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] vec_t;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic vec_t lsb_isolate(vec_t v);
    return v & (~v + 1'b1);
  endfunction
  function automatic int unsigned onehot_to_idx(vec_t v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++)
      if (v[i]) idx = idx | unsigned'(i);
    return idx;
  endfunction
endpackage

// File: rtl/lsb_isolate_vec.sv
// lsb_isolate_vec: keeps only the lowest set bit of vec (zero stays zero)
module lsb_isolate_vec
  import arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] lsb
);
  assign lsb = WIDTH'(lsb_isolate(vec_t'(vec)));
endmodule

// File: rtl/rr_lsb_arbiter.sv
// rr_lsb_arbiter: round-robin one-hot arbiter with optional grant lock until ack
module rr_lsb_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  bit LOCK    = 1'b1,
  localparam int IDXW    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ack,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDXW-1:0]    gnt_idx
);
  state_t             state;
  logic [IDXW-1:0]    ptr, arb_ptr, pick_idx;
  logic [NUM_REQ-1:0] arb_req, mask, masked, pick_m, pick_u, pick;
  logic               done;
  function automatic logic [IDXW-1:0] wrap_inc(logic [IDXW-1:0] i);
    return (i == IDXW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction
  // a locked grant ends on ack or when the grantee withdraws its request
  assign done    = LOCK && state == GRANT && (ack || !req[gnt_idx]);
  assign arb_ptr = done ? wrap_inc(gnt_idx) : ptr;
  assign arb_req = done ? req & ~gnt : req;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_mask
    assign mask[i] = IDXW'(i) >= arb_ptr;
  end
  assign masked = arb_req & mask;
  lsb_isolate_vec #(.WIDTH(NUM_REQ)) u_masked (.vec(masked),  .lsb(pick_m));
  lsb_isolate_vec #(.WIDTH(NUM_REQ)) u_plain  (.vec(arb_req), .lsb(pick_u));
  assign pick     = |masked ? pick_m : pick_u;
  assign pick_idx = IDXW'(onehot_to_idx(vec_t'(pick)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
    end else if (!LOCK || state == IDLE || done) begin
      gnt       <= pick;
      gnt_valid <= |pick;
      gnt_idx   <= pick_idx;
      state     <= |pick ? GRANT : IDLE;
      if (!LOCK && |pick) ptr <= wrap_inc(pick_idx);
      else if (done) ptr <= arb_ptr;
    end
  end
endmodule

// File: tb/tb_rr_lsb_arbiter.sv
// tb_rr_lsb_arbiter: directed vectors for locked and free-running arbiters
module tb_rr_lsb_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req_l = '0, req_f = '0;
  logic       ack_l = 1'b0, ack_f = 1'b0;
  logic [3:0] gnt_l, gnt_f;
  logic       val_l, val_f;
  logic [1:0] idx_l, idx_f;
  int         errs = 0, checks = 0;
  always #5 clk = ~clk;
  rr_lsb_arbiter #(.NUM_REQ(4), .LOCK(1'b1)) u_lock (
    .clk(clk), .rst(rst), .req(req_l), .ack(ack_l),
    .gnt(gnt_l), .gnt_valid(val_l), .gnt_idx(idx_l)
  );
  rr_lsb_arbiter #(.NUM_REQ(4), .LOCK(1'b0)) u_free (
    .clk(clk), .rst(rst), .req(req_f), .ack(ack_f),
    .gnt(gnt_f), .gnt_valid(val_f), .gnt_idx(idx_f)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic exp_l(input string tag, input logic [3:0] g, input logic [1:0] i);
    chk({tag, ".gnt"}, 32'(gnt_l), 32'(g));
    chk({tag, ".valid"}, 32'(val_l), 32'(|g));
    chk({tag, ".idx"}, 32'(idx_l), 32'(i));
  endtask
  task automatic exp_f(input string tag, input logic [3:0] g, input logic [1:0] i);
    chk({tag, ".gnt"}, 32'(gnt_f), 32'(g));
    chk({tag, ".valid"}, 32'(val_f), 32'(|g));
    chk({tag, ".idx"}, 32'(idx_f), 32'(i));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1 rst = 1'b1;
    #1;
    exp_l("reset_l", 4'b0000, 2'd0);
    exp_f("reset_f", 4'b0000, 2'd0);
    #5 rst = 1'b0;
    tick();
    req_l = 4'b1010; ack_l = 1'b1;
    tick();
    exp_l("first", 4'b0010, 2'd1);
    ack_l = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_l("hold", 4'b0010, 2'd1);
    end
    ack_l = 1'b1;
    tick();
    exp_l("ack_next", 4'b1000, 2'd3);
    req_l = 4'b1011;
    tick();
    exp_l("ack_wrap", 4'b0001, 2'd0);
    req_l = 4'b1111;
    tick(); exp_l("rot1", 4'b0010, 2'd1);
    tick(); exp_l("rot2", 4'b0100, 2'd2);
    tick(); exp_l("rot3", 4'b1000, 2'd3);
    tick(); exp_l("rot0", 4'b0001, 2'd0);
    tick(); exp_l("rot1b", 4'b0010, 2'd1);
    tick(); exp_l("rot2b", 4'b0100, 2'd2);
    req_l = 4'b1001; ack_l = 1'b0;
    tick();
    exp_l("abort", 4'b1000, 2'd3);
    req_l = 4'b1000; ack_l = 1'b1;
    tick();
    exp_l("single_gap", 4'b0000, 2'd0);
    tick();
    exp_l("single_regrant", 4'b1000, 2'd3);
    req_l = 4'b0010;
    tick();
    exp_l("to1", 4'b0010, 2'd1);
    req_l = 4'b0110;
    tick();
    exp_l("to2", 4'b0100, 2'd2);
    ack_l = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_l("async_rst", 4'b0000, 2'd0);
    req_l = 4'b1001;
    #2 rst = 1'b0;
    tick();
    exp_l("ptr_cleared", 4'b0001, 2'd0);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    req_l = 4'b1100;
    tick();
    exp_l("post_rst", 4'b0100, 2'd2);
    req_l = 4'b0000; ack_l = 1'b1;
    tick();
    exp_l("drain", 4'b0000, 2'd0);
    ack_l = 1'b0;
    req_f = 4'b1111;
    tick(); exp_f("free0", 4'b0001, 2'd0); ack_f = ~ack_f;
    tick(); exp_f("free1", 4'b0010, 2'd1); ack_f = ~ack_f;
    tick(); exp_f("free2", 4'b0100, 2'd2); ack_f = ~ack_f;
    tick(); exp_f("free3", 4'b1000, 2'd3); ack_f = ~ack_f;
    tick(); exp_f("free_wrap", 4'b0001, 2'd0);
    req_f = 4'b1010;
    tick(); exp_f("free_sparse1", 4'b0010, 2'd1);
    tick(); exp_f("free_sparse3", 4'b1000, 2'd3);
    tick(); exp_f("free_sparse_wrap", 4'b0010, 2'd1);
    req_f = 4'b0000;
    tick(); exp_f("free_none", 4'b0000, 2'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
